// File: rtl/input_port_receiver.sv
// input_port_receiver
//   Receiving end of a router-to-router link, one instance per router input
//   port. It answers the upstream request with a one-cycle grant, buffers the
//   packet in a small FIFO and reports full back upstream. Buffered packets are
//   presented first-word-fall-through to the local routing/crossbar logic.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   reqUpStr   request from the upstream output controller, held until granted
//   gntUpStr   grant to upstream, one-cycle pulse per accepted packet
//   full       FIFO full indication to upstream (registered)
//   PacketIn   packet from upstream, valid while reqUpStr=1
//   rd_en      pop request from the local router logic
//   PacketOut  FIFO head entry (FWFT), 0 when empty
//   empty      FIFO empty (registered)
//   count      current occupancy, 0..DEPTH (registered)
//
// Optional feature (macro INPORT_STATS_EN)
//   pkt_cnt    accepted-packet counter, wraps at 16 bits
//   stall_cnt  cycles a request waited in IDLE on a full FIFO, saturating
module input_port_receiver #(
  parameter int unsigned packetwidth = 55,
  parameter int unsigned datawidth   = 25,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reqUpStr,
  output logic                   gntUpStr,
  output logic                   full,
  input  logic [packetwidth-1:0] PacketIn,
  input  logic                   rd_en,
  output logic [packetwidth-1:0] PacketOut,
  output logic                   empty,
  output logic [ADDR_W:0]        count
`ifdef INPORT_STATS_EN
  ,
  output logic [15:0]            pkt_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  // The direction field [datawidth+2:datawidth] must fit in the packet and
  // the pointer width must address exactly DEPTH entries.
  if (datawidth + 3 > packetwidth) begin : gen_bad_width
    $error("input_port_receiver: direction field exceeds packet width");
  end
  if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : gen_bad_depth
    $error("input_port_receiver: DEPTH must be 2**ADDR_W and at least 2");
  end

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]             state;
  logic [1:0]             stateNext;
  logic                   gntNext;
  logic                   wrEn_c;
  logic                   rdEn_c;
  logic [CNT_W-1:0]       countNext;
  logic [ADDR_W-1:0]      wrPtr;
  logic [ADDR_W-1:0]      rdPtr;
  logic [packetwidth-1:0] mem [DEPTH];

  // Handshake FSM next state; the write is decided on the registered full.
  always_comb begin
    stateNext = state;
    gntNext   = 1'b0;
    wrEn_c    = 1'b0;
    case (state)
      IDLE: begin
        if (reqUpStr && !full) begin
          wrEn_c    = 1'b1;
          gntNext   = 1'b1;
          stateNext = GRANT;
        end
      end
      // Request is still high here; it is ignored so only one write happens.
      GRANT:   stateNext = RELEASE;
      RELEASE: if (!reqUpStr) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gntUpStr <= 1'b0;
    end else begin
      state    <= stateNext;
      gntUpStr <= gntNext;
    end
  end

  // Occupancy is tracked separately from the wrapping pointers.
  always_comb begin
    rdEn_c    = rd_en && !empty;
    countNext = count + CNT_W'(wrEn_c) - CNT_W'(rdEn_c);
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wrEn_c) wrPtr <= wrPtr + ADDR_W'(1);
      if (rdEn_c) rdPtr <= rdPtr + ADDR_W'(1);
      count <= countNext;
      full  <= (countNext == CNT_W'(DEPTH));
      empty <= (countNext == '0);
    end
  end

  // Packet storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wrEn_c) mem[wrPtr] <= PacketIn;
  end

  // First-word-fall-through head, forced to zero while empty.
  assign PacketOut = empty ? '0 : mem[rdPtr];

`ifdef INPORT_STATS_EN
  // Link statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (wrEn_c) pkt_cnt <= pkt_cnt + 16'd1;
      if ((state == IDLE) && reqUpStr && full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_port_receiver.sv
// Directed bench for input_port_receiver: reset, single handshake, fill and
// stall on full, FWFT drain order, simultaneous read/write, pointer wrap,
// asynchronous reset during a handshake, and the optional statistics.
module tb_input_port_receiver;

  logic        clk;
  logic        reset;
  logic        reqUpStr;
  logic        gntUpStr;
  logic        full;
  logic [54:0] PacketIn;
  logic        rd_en;
  logic [54:0] PacketOut;
  logic        empty;
  logic [2:0]  count;
`ifdef INPORT_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] stall_cnt;
`endif

  int nVec = 0;
  int nErr = 0;

  input_port_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .reqUpStr  (reqUpStr),
    .gntUpStr  (gntUpStr),
    .full      (full),
    .PacketIn  (PacketIn),
    .rd_en     (rd_en),
    .PacketOut (PacketOut),
    .empty     (empty),
    .count     (count)
`ifdef INPORT_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise the request and wait (bounded) for the edge that grants it.
  task automatic send(input logic [54:0] d);
    bit g;
    g        = 1'b0;
    reqUpStr = 1'b1;
    PacketIn = d;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gntUpStr === 1'b1) begin
        g = 1'b1;
        break;
      end
    end
    check("grant", 64'(g), 64'd1);
  endtask

  // Upstream holds the request through the grant edge, then drops it.
  task automatic finishHs();
    tick();
    check("gnt_pulse", 64'(gntUpStr), 64'd0);
    reqUpStr = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b0;
    reqUpStr = 1'b1;
    PacketIn = 55'h1;
    rd_en    = 1'b0;
    repeat (3) tick();
    check("rst_gnt",   64'(gntUpStr),  64'd0);
    check("rst_empty", 64'(empty),     64'd1);
    check("rst_full",  64'(full),      64'd0);
    check("rst_count", 64'(count),     64'd0);
    check("rst_pout",  64'(PacketOut), 64'd0);
    reset    = 1'b1;
    reqUpStr = 1'b0;
    tick();

    // Single transfer; request held through the grant edge.
    send(55'h0_0000_0ABCDE);
    check("single_count", 64'(count),     64'd1);
    check("single_empty", 64'(empty),     64'd0);
    check("single_pout",  64'(PacketOut), 64'h0ABCDE);
    finishHs();
    check("single_nodup", 64'(count), 64'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("single_pop_empty", 64'(empty),     64'd1);
    check("single_pop_count", 64'(count),     64'd0);
    check("single_pop_pout",  64'(PacketOut), 64'd0);

    // Fill to DEPTH, then a fifth request stalls until one pop.
    for (int i = 0; i < 4; i++) begin
      send(55'(11 + i));
      finishHs();
    end
    check("fill_count", 64'(count),     64'd4);
    check("fill_full",  64'(full),      64'd1);
    check("fill_head",  64'(PacketOut), 64'd11);
    reqUpStr = 1'b1;
    PacketIn = 55'd15;
    repeat (2) begin
      tick();
      check("stall_nogrant", 64'(gntUpStr), 64'd0);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("fullrd_count", 64'(count),     64'd3);
    check("fullrd_full",  64'(full),      64'd0);
    check("fullrd_gnt",   64'(gntUpStr),  64'd0);
    check("fullrd_head",  64'(PacketOut), 64'd12);
    tick();
    check("late_gnt",   64'(gntUpStr), 64'd1);
    check("late_count", 64'(count),    64'd4);
    check("late_full",  64'(full),     64'd1);
    finishHs();
`ifdef INPORT_STATS_EN
    check("stats_pkt",   64'(pkt_cnt),   64'd6);
    check("stats_stall", 64'(stall_cnt), 64'd3);
`endif

    // Continuous drain in write order, then pops on empty are ignored.
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(PacketOut), 64'(12 + i));
      tick();
    end
    check("drain_empty", 64'(empty),     64'd1);
    check("drain_count", 64'(count),     64'd0);
    check("drain_pout",  64'(PacketOut), 64'd0);
    repeat (2) tick();
    check("underflow_count", 64'(count), 64'd0);
    check("underflow_empty", 64'(empty), 64'd1);
    rd_en = 1'b0;

    // Write and read on the same edge with two entries buffered.
    send(55'd21);
    finishHs();
    send(55'd22);
    finishHs();
    check("sim_pre_count", 64'(count), 64'd2);
    reqUpStr = 1'b1;
    PacketIn = 55'd23;
    rd_en    = 1'b1;
    tick();
    rd_en = 1'b0;
    check("sim_gnt",   64'(gntUpStr),  64'd1);
    check("sim_count", 64'(count),     64'd2);
    check("sim_head",  64'(PacketOut), 64'd22);
    finishHs();
    rd_en = 1'b1;
    check("sim_rd0", 64'(PacketOut), 64'd22);
    tick();
    check("sim_rd1", 64'(PacketOut), 64'd23);
    tick();
    rd_en = 1'b0;
    check("sim_empty", 64'(empty), 64'd1);

    // Ten packets through the wrapping pointers.
    for (int i = 1; i <= 10; i++) begin
      send(55'(i));
      finishHs();
      check("wrap_order", 64'(PacketOut), 64'(i));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    check("wrap_empty", 64'(empty), 64'd1);
`ifdef INPORT_STATS_EN
    check("stats_pkt_end", 64'(pkt_cnt), 64'd19);
`endif

    // Asynchronous reset right after a grant, and held with a pending request.
    reqUpStr = 1'b1;
    PacketIn = 55'h77;
    tick();
    check("pre_rst_gnt", 64'(gntUpStr), 64'd1);
    reset = 1'b0;
    #1;
    check("async_gnt",   64'(gntUpStr), 64'd0);
    check("async_count", 64'(count),    64'd0);
    check("async_empty", 64'(empty),    64'd1);
    repeat (2) tick();
    check("rsthold_gnt",   64'(gntUpStr),  64'd0);
    check("rsthold_count", 64'(count),     64'd0);
    check("rsthold_pout",  64'(PacketOut), 64'd0);
`ifdef INPORT_STATS_EN
    check("rst_pkt",   64'(pkt_cnt),   64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
`endif
    reqUpStr = 1'b0;
    reset    = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/input_port_receiver.md
Name: input_port_receiver

Overview:
- Receiving end of the router-to-router link: one instance per router input port, facing one upstream output controller.
- Answers the upstream request with a single-cycle grant, captures the packet into a local FIFO, and drives the full indication back upstream.
- Presents buffered packets first-word-fall-through to the local routing/crossbar logic.

Parameters:
- packetwidth, 55, packet bus width.
- datawidth, 25, payload width; direction field is bits [datawidth+2:datawidth].
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- reqUpStr  input  1  request from upstream output controller; held until granted.
- gntUpStr  output  1  grant to upstream; one-cycle pulse per accepted packet.
- full  output  1  FIFO full indication to upstream.
- PacketIn  input  packetwidth  packet from upstream; valid while reqUpStr=1.
- rd_en  input  1  pop request from local router logic.
- PacketOut  output  packetwidth  FIFO head entry (FWFT); 0 when empty.
- empty  output  1  FIFO empty.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous on negedge reset: gntUpStr=0, full=0, empty=1, count=0, PacketOut=0, pointers=0, state=IDLE. Reset mid-handshake discards the pending packet and sends no grant.
- full, empty and count are registered and reflect occupancy after the last edge; full=(count==DEPTH), empty=(count==0).
- State machine:
  - IDLE: if reqUpStr=1 and full=0, write PacketIn at wr_ptr, set gntUpStr<=1, go to GRANT. If reqUpStr=1 and full=1, write nothing, no grant, stay in IDLE; the request stays pending until space frees.
  - GRANT: gntUpStr<=0; go to RELEASE. reqUpStr is still 1 in this cycle (upstream drops it on the edge where it sees the grant) and is ignored; no second write.
  - RELEASE: wait for reqUpStr=0, then go to IDLE. This guarantees one write per request.
- Minimum spacing between accepted packets is 3 cycles.
- Handshake latency: the grant appears on the edge after request and not-full are sampled.
- Read side: when rd_en=1 and empty=0, rd_ptr advances and PacketOut shows the next entry combinationally from memory. rd_en while empty is ignored; no underflow.
- Simultaneous write and read on one edge: count unchanged, both pointers advance.
- Full plus read: the write is decided on the registered full=1, so no write occurs that cycle. The write happens in the cycle after full drops.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is computed separately and never wraps.
- Packets are stored unmodified; the direction field already arrives as 000 from upstream.

Optional Feature:
- Macro: INPORT_STATS_EN.
- Defined:
  - Adds output pkt_cnt [15:0]: increments on every accepted write and wraps 0xFFFF->0x0000; reset 0.
  - Adds output stall_cnt [15:0]: increments each cycle with reqUpStr=1, full=1 in IDLE; saturates at 0xFFFF; reset 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset with reqUpStr=1, PacketIn=55'h1 -> gntUpStr=0, empty=1, count=0, PacketOut=0 while reset=0.
- Single transfer, PacketIn=55'h0_0000_0ABCDE, req at edge 0 -> gntUpStr=1 exactly one cycle (edge 1), count=1, PacketOut=55'h0ABCDE, empty=0. Req held through edge 1 causes no second write.
- Four back-to-back upstream requests with DEPTH=4 and no reads -> count=4, full=1. A fifth req gets no grant. rd_en for one cycle -> count=3, full=0, then the grant for the fifth arrives.
- Fill to 3 then pop all with rd_en=1 continuous -> PacketOut order matches write order. After the last pop, empty=1 and PacketOut=0. Further rd_en leaves count=0.
- Simultaneous write-grant edge and rd_en with count=2 -> count stays 2; pointers wrap correctly over 10 packets with data 1..10 read back in order.
- With INPORT_STATS_EN: 5 accepted packets plus 3 stalled cycles -> pkt_cnt=5, stall_cnt=3. Reset clears both to 0.
